equal_cmp_arbiter: RTL and testbench

- Shares one equal_32 comparator between two requesters:
  - port 0: branch unit (BEQ/BNE);
  - port 1: trap unit (TEQ/TNE).
- Round-robin arbitration, one outstanding comparison at a time.
- Registered operands and result, with a valid/ready handshake on both the request and response sides.
- Sits in the execute stage beside the ALU.

---
 rtl/equal_cmp_arbiter_pkg.sv | 13 +
 rtl/equal_cmp_arbiter_if.sv | 36 +++
 rtl/equal_cmp_arbiter_equal_32.sv | 10 +
 rtl/equal_cmp_arbiter.sv | 103 ++++++++++
 tb/tb_equal_cmp_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/equal_cmp_arbiter_pkg.sv
// Shared encodings for the branch/trap equality-compare arbiter.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PORT_BR   = 1'b0;
    localparam logic PORT_TRAP = 1'b1;

endpackage

// File: rtl/equal_cmp_arbiter_if.sv
// Request/response handshake bundle for both requesters of the compare arbiter.
interface equal_cmp_arbiter_if #(parameter int WIDTH = 32);

    logic             req_valid_0;
    logic             req_ready_0;
    logic [WIDTH-1:0] req_a_0;
    logic [WIDTH-1:0] req_b_0;
    logic             req_inv_0;
    logic             resp_valid_0;
    logic             resp_ready_0;
    logic             resp_result_0;

    logic             req_valid_1;
    logic             req_ready_1;
    logic [WIDTH-1:0] req_a_1;
    logic [WIDTH-1:0] req_b_1;
    logic             req_inv_1;
    logic             resp_valid_1;
    logic             resp_ready_1;
    logic             resp_result_1;

    modport master (
        output req_valid_0, req_a_0, req_b_0, req_inv_0, resp_ready_0,
        output req_valid_1, req_a_1, req_b_1, req_inv_1, resp_ready_1,
        input  req_ready_0, resp_valid_0, resp_result_0,
        input  req_ready_1, resp_valid_1, resp_result_1
    );

    modport slave (
        input  req_valid_0, req_a_0, req_b_0, req_inv_0, resp_ready_0,
        input  req_valid_1, req_a_1, req_b_1, req_inv_1, resp_ready_1,
        output req_ready_0, resp_valid_0, resp_result_0,
        output req_ready_1, resp_valid_1, resp_result_1
    );

endinterface

// File: rtl/equal_cmp_arbiter_equal_32.sv
// Existing 32-bit bitwise equality comparator shared by the arbiter.
module equal_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        eq
);

    assign eq = (a == b);

endmodule

// File: rtl/equal_cmp_arbiter.sv
// Round-robin arbiter sharing one equal_32 between the branch and trap units.
// One comparison in flight: IDLE (accept) -> CMP (evaluate) -> RESP (hold until taken).
module equal_cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    equal_cmp_arbiter_if.slave   bus,
    output logic                 busy
);

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic             inv_q, inv_d;
    logic             result_q, result_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic             eq;
    logic             grant_vld;
    logic             grant_port;

    equal_32 u_eq (
        .a  (a_q),
        .b  (b_q),
        .eq (eq)
    );

    // On a tie the port that did not win last time goes next.
    always_comb begin
        grant_vld  = bus.req_valid_0 | bus.req_valid_1;
        grant_port = PORT_BR;
        if (bus.req_valid_0 && bus.req_valid_1)
            grant_port = ~last_grant_q;
        else if (bus.req_valid_1)
            grant_port = PORT_TRAP;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        inv_d        = inv_q;
        result_d     = result_q;
        a_d          = a_q;
        b_d          = b_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d          = (grant_port == PORT_TRAP) ? bus.req_a_1   : bus.req_a_0;
                    b_d          = (grant_port == PORT_TRAP) ? bus.req_b_1   : bus.req_b_0;
                    inv_d        = (grant_port == PORT_TRAP) ? bus.req_inv_1 : bus.req_inv_0;
                    owner_d      = grant_port;
                    last_grant_d = grant_port;
                    state_d      = CMP;
                end
            end
            CMP: begin
                result_d = eq ^ inv_q;
                state_d  = RESP;
            end
            RESP: begin
                if ((owner_q == PORT_TRAP) ? bus.resp_ready_1 : bus.resp_ready_0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_0   = (state_q == IDLE) && grant_vld && (grant_port == PORT_BR);
        bus.req_ready_1   = (state_q == IDLE) && grant_vld && (grant_port == PORT_TRAP);
        bus.resp_valid_0  = (state_q == RESP) && (owner_q == PORT_BR);
        bus.resp_valid_1  = (state_q == RESP) && (owner_q == PORT_TRAP);
        bus.resp_result_0 = bus.resp_valid_0 & result_q;
        bus.resp_result_1 = bus.resp_valid_1 & result_q;
        busy              = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_TRAP;
            owner_q      <= PORT_BR;
            inv_q        <= 1'b0;
            result_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            inv_q        <= inv_d;
            result_q     <= result_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

endmodule

// File: tb/tb_equal_cmp_arbiter.sv
// Self-checking bench: vector table plus hand sequences, responses checked by a scoreboard.
module tb_equal_cmp_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;

    equal_cmp_arbiter_if #(.WIDTH(32)) bus_if ();

    equal_cmp_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        logic [31:0] a;
        logic [31:0] b;
        bit          inv;
        bit          exp;
    } vec_t;

    typedef struct {
        bit port;
        bit exp;
    } sb_t;

    typedef struct {
        bit port;
        int cyc;
    } grant_t;

    sb_t    sb[$];
    grant_t gl[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    vec_t   tbl[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every presented response must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset) begin
            chk("ready_onehot", bus_if.req_ready_0 & bus_if.req_ready_1, 0);
            chk("resp_overlap", bus_if.resp_valid_0 & bus_if.resp_valid_1, 0);
            if (bus_if.req_valid_0 && bus_if.req_ready_0) gl.push_back('{port: 1'b0, cyc: cyc});
            if (bus_if.req_valid_1 && bus_if.req_ready_1) gl.push_back('{port: 1'b1, cyc: cyc});
            if (bus_if.resp_valid_0 || bus_if.resp_valid_1) begin
                chk("resp_outstanding", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    chk("resp_port", bus_if.resp_valid_1, sb[0].port);
                    chk("resp_result", bus_if.resp_valid_1 ? bus_if.resp_result_1 : bus_if.resp_result_0,
                        sb[0].exp);
                    if ((bus_if.resp_valid_0 && bus_if.resp_ready_0) ||
                        (bus_if.resp_valid_1 && bus_if.resp_ready_1))
                        void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit p, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input bit inv);
        if (!p) begin
            bus_if.req_valid_0 = v; bus_if.req_a_0 = a; bus_if.req_b_0 = b; bus_if.req_inv_0 = inv;
        end else begin
            bus_if.req_valid_1 = v; bus_if.req_a_1 = a; bus_if.req_b_1 = b; bus_if.req_inv_1 = inv;
        end
    endtask

    function automatic bit rdy(input bit p);
        return p ? bus_if.req_ready_1 : bus_if.req_ready_0;
    endfunction

    // Holds the request until accepted; returns #1 after the accepting edge with valid still high.
    task automatic send(input bit p, input logic [31:0] a, input logic [31:0] b, input bit inv,
                        input bit exp);
        bit got = 1'b0;
        drive(p, 1'b1, a, b, inv);
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = rdy(p);
        end
        chk("send_accept", got, 1);
        if (got) sb.push_back('{port: p, exp: exp});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && sb.size() != 0; n++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        gl.delete();
    endtask

    initial begin
        tbl[0] = '{port: 1'b0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, inv: 1'b0, exp: 1'b1};
        tbl[1] = '{port: 1'b1, a: 32'h0000_0001, b: 32'h0000_0000, inv: 1'b1, exp: 1'b1};
        tbl[2] = '{port: 1'b1, a: 32'h8045_1C00, b: 32'h8045_1C00, inv: 1'b1, exp: 1'b0};
        tbl[3] = '{port: 1'b0, a: 32'h0000_0000, b: 32'h0000_0001, inv: 1'b0, exp: 1'b0};
        tbl[4] = '{port: 1'b1, a: 32'h8000_0000, b: 32'h0000_0000, inv: 1'b0, exp: 1'b0};
        tbl[5] = '{port: 1'b0, a: 32'h1234_5678, b: 32'h1234_5678, inv: 1'b1, exp: 1'b0};
        tbl[6] = '{port: 1'b1, a: 32'hA5A5_A5A5, b: 32'h5A5A_5A5A, inv: 1'b1, exp: 1'b1};
        tbl[7] = '{port: 1'b0, a: 32'h0000_0000, b: 32'h0000_0000, inv: 1'b0, exp: 1'b1};

        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        bus_if.resp_ready_0 = 1'b1;
        bus_if.resp_ready_1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid_0", bus_if.resp_valid_0, 0);
        chk("rst_resp_valid_1", bus_if.resp_valid_1, 0);
        chk("rst_resp_result_0", bus_if.resp_result_0, 0);
        chk("rst_resp_result_1", bus_if.resp_result_1, 0);
        @(posedge clk); #1;

        // Single request: latency, busy and quiet port 1
        send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("single_cmp_busy", busy, 1);
        chk("single_cmp_rv0", bus_if.resp_valid_0, 0);
        @(negedge clk);
        chk("single_resp_rv0", bus_if.resp_valid_0, 1);
        chk("single_resp_res0", bus_if.resp_result_0, 1);
        chk("single_resp_busy", busy, 1);
        chk("single_rv1", bus_if.resp_valid_1, 0);
        chk("single_res1", bus_if.resp_result_1, 0);
        @(posedge clk); #1;
        drain();

        // Vector table, one transaction at a time
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].inv, tbl[i].exp);
            drive(tbl[i].port, 1'b0, '0, '0, 1'b0);
            drain();
        end

        // Simultaneous requests straight out of reset: port 0 first
        do_reset();
        fork
            send(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
            send(1'b1, 32'h0004_0000, 32'h0041_0000, 1'b0, 1'b0);
        join
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drain();
        chk("simul_grants", gl.size(), 2);
        if (gl.size() == 2) begin
            chk("simul_first", gl[0].port, 0);
            chk("simul_second", gl[1].port, 1);
        end

        // Continuous contention: strict alternation, 3-cycle issue interval
        do_reset();
        fork
            begin
                for (int k = 0; k < 3; k++) send(1'b0, k, k, 1'b0, 1'b1);
                drive(1'b0, 1'b0, '0, '0, 1'b0);
            end
            begin
                for (int k = 0; k < 3; k++) send(1'b1, k, k + 1, 1'b0, 1'b0);
                drive(1'b1, 1'b0, '0, '0, 1'b0);
            end
        join
        drain();
        chk("cont_grants", gl.size(), 6);
        if (gl.size() == 6) begin
            for (int k = 0; k < 6; k++) chk($sformatf("cont_order_%0d", k), gl[k].port, k % 2);
            for (int k = 1; k < 6; k++) chk($sformatf("cont_gap_%0d", k), gl[k].cyc - gl[k-1].cyc, 3);
        end

        // Backpressure on port 0 while port 1 waits
        do_reset();
        bus_if.resp_ready_0 = 1'b0;
        send(1'b0, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0004, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rv0", bus_if.resp_valid_0, 1);
            chk("bp_res0", bus_if.resp_result_0, 1);
            chk("bp_rdy1", bus_if.req_ready_1, 0);
        end
        @(posedge clk); #1;
        bus_if.resp_ready_0 = 1'b1;
        @(negedge clk);
        chk("bp_release_rdy1", bus_if.req_ready_1, 0);
        @(negedge clk);
        chk("bp_grant_rdy1", bus_if.req_ready_1, 1);
        if (bus_if.req_ready_1) sb.push_back('{port: 1'b1, exp: 1'b0});
        @(posedge clk); #1;
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drain();

        // Reset during CMP of a port 1 transaction
        do_reset();
        send(1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        gl.delete();
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_rv1", bus_if.resp_valid_1, 0);
        @(posedge clk); #1;
        fork
            send(1'b0, 32'h0000_0009, 32'h0000_0009, 1'b0, 1'b1);
            send(1'b1, 32'h0000_0009, 32'h0000_0008, 1'b0, 1'b0);
        join
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drain();
        chk("midrst_grants", gl.size(), 2);
        if (gl.size() == 2) chk("midrst_first", gl[0].port, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
